// File: rtl/pointwise_conv_engine_pkg.sv
// Shared fixed-point helpers, FSM state type and default Q-format constants
// for the CNN layer engines.
package cnn_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_FRAC  = 14;
    localparam int unsigned SAT_W     = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Floor-rescale acc + bias back to the Q format, then ReLU or saturate.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] bias,
        input int unsigned             frac,
        input logic                    relu,
        input int unsigned             width
    );
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = (acc + (bias <<< frac)) >>> frac;
        hi = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
        lo = ~hi;
        if (relu && s < 0)
            sat_shift = '0;
        else if (s > hi)
            sat_shift = hi;
        else if (s < lo)
            sat_shift = lo;
        else
            sat_shift = s;
    endfunction

endpackage

// File: rtl/pointwise_conv_engine_if.sv
// Input-feature stream and output-vector stream of the pointwise engine.
interface pointwise_conv_engine_if
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned COUT  = 112,
    parameter int unsigned WOUT  = 8
);
    localparam int unsigned PIX_W = $clog2(WOUT * WOUT);

    logic [WIDTH-1:0]           ifm;
    logic                       ifm_valid;
    logic                       ifm_ready;
    logic [COUT-1:0][WIDTH-1:0] ofm;
    logic                       ofm_valid;
    logic [PIX_W-1:0]           ofm_pix;

    modport master (output ifm, ifm_valid, input ifm_ready, ofm, ofm_valid, ofm_pix);
    modport slave  (input ifm, ifm_valid, output ifm_ready, ofm, ofm_valid, ofm_pix);

endinterface

// File: rtl/pointwise_conv_engine_pw_lane.sv
// One MAC lane: signed product, channel accumulator and bias/rescale/saturate.
module pw_lane
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC,
    parameter int unsigned CHIN  = 512,
    parameter int unsigned RELU  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    input  logic signed [WIDTH-1:0] bias,
    input  logic                    beat,
    input  logic                    first,
    input  logic                    fin,
    output logic signed [WIDTH-1:0] ofm
);
    localparam int unsigned ACC_W = 2 * WIDTH + $clog2(CHIN);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc;

    always_comb prod = x * w;

    // The first-channel beat overwrites, so no clear is needed between pixels.
    always_ff @(posedge clk) begin
        if (beat)
            acc <= first ? ACC_W'(prod) : acc + ACC_W'(prod);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ofm <= '0;
        else if (fin)
            ofm <= WIDTH'(sat_shift(SAT_W'(acc), SAT_W'(bias), FRAC, RELU != 0, WIDTH));
    end

endmodule

// File: rtl/pointwise_conv_engine.sv
// 1x1 convolution engine: layer FSM, channel/pixel counters, input beat
// registers and COUT parallel MAC lanes.
module pointwise_conv_engine
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned FRAC  = DEF_FRAC,
    parameter int unsigned CHIN  = 512,
    parameter int unsigned COUT  = 112,
    parameter int unsigned WOUT  = 8,
    parameter int unsigned RELU  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [$clog2(CHIN)-1:0]    weight_addr,
    input  logic [COUT-1:0][WIDTH-1:0] weight_data,
    input  logic [COUT-1:0][WIDTH-1:0] bias,
    output logic                       layer_done,
    input  logic                       done_ack,
    pointwise_conv_engine_if.slave     stream
);
    localparam int unsigned CH_W  = $clog2(CHIN);
    localparam int unsigned NPIX  = WOUT * WOUT;
    localparam int unsigned PIX_W = $clog2(NPIX);

    state_t                     state, state_nx;
    logic [CH_W-1:0]            ch;
    logic [PIX_W-1:0]           pix;
    logic [1:0]                 drain_cnt;
    logic                       xfer, ch_wrap, layer_end;
    logic                       beat_q, first_q, last_q, fin_q;
    logic [PIX_W-1:0]           pix_q, fin_pix;
    logic [WIDTH-1:0]           x_q;
    logic [COUT-1:0][WIDTH-1:0] w_q, ofm_vec;

    always_comb begin
        ch_wrap     = (ch == CH_W'(CHIN - 1));
        layer_end   = ch_wrap && (pix == PIX_W'(NPIX - 1));
        xfer        = stream.ifm_valid && stream.ifm_ready;
        weight_addr = ch;
        stream.ofm  = ofm_vec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // DRAIN covers the two pipeline edges plus one more so that layer_done
    // rises one cycle after the final ofm_valid pulse.
    always_comb begin
        state_nx         = state;
        stream.ifm_ready = 1'b0;
        layer_done       = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN: begin
                stream.ifm_ready = 1'b1;
                if (xfer && layer_end) state_nx = DRAIN;
            end
            DRAIN: if (drain_cnt == 2'd2) state_nx = DONE;
            DONE: begin
                layer_done = 1'b1;
                if (done_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch        <= '0;
            pix       <= '0;
            drain_cnt <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
            if (state == IDLE && start) begin
                ch  <= '0;
                pix <= '0;
            end else if (xfer) begin
                ch <= ch_wrap ? '0 : ch + CH_W'(1);
                if (ch_wrap)
                    pix <= layer_end ? '0 : pix + PIX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_q           <= 1'b0;
            fin_q            <= 1'b0;
            stream.ofm_valid <= 1'b0;
            stream.ofm_pix   <= '0;
        end else begin
            beat_q           <= xfer;
            fin_q            <= beat_q && last_q;
            stream.ofm_valid <= fin_q;
            if (fin_q) stream.ofm_pix <= fin_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            x_q     <= stream.ifm;
            w_q     <= weight_data;
            first_q <= (ch == '0);
            last_q  <= ch_wrap;
            pix_q   <= pix;
        end
        if (beat_q) fin_pix <= pix_q;
    end

    for (genvar i = 0; i < COUT; i++) begin : g_lane
        pw_lane #(
            .WIDTH(WIDTH),
            .FRAC (FRAC),
            .CHIN (CHIN),
            .RELU (RELU)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .x    (x_q),
            .w    (w_q[i]),
            .bias (bias[i]),
            .beat (beat_q),
            .first(first_q),
            .fin  (fin_q),
            .ofm  (ofm_vec[i])
        );
    end

endmodule

// File: tb/tb_pointwise_conv_engine.sv
// Randomised bench for pointwise_conv_engine against a plain-arithmetic
// reference model (small RELU=1/RELU=0 pair plus a default-size instance).
module tb_pointwise_conv_engine;

    localparam int CH_S = 4;
    localparam int NP_S = 4;
    localparam int CH_D = 512;
    localparam int CO_D = 112;
    localparam int NP_D = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- small pair: CHIN=4 COUT=2 WOUT=2 FRAC=8 ----------------
    logic             start_s = 1'b0, ack_s = 1'b0;
    logic             done_s0, done_s1;
    logic [1:0]       waddr_s0, waddr_s1;
    logic [1:0][15:0] wdata_s, bias_s;
    logic [1:0][15:0] rom_s [CH_S];
    int               ifm_s [NP_S*CH_S];

    pointwise_conv_engine_if #(.WIDTH(16), .COUT(2), .WOUT(2)) s0 ();
    pointwise_conv_engine_if #(.WIDTH(16), .COUT(2), .WOUT(2)) s1 ();

    assign wdata_s      = rom_s[waddr_s0];
    assign s1.ifm       = s0.ifm;
    assign s1.ifm_valid = s0.ifm_valid;

    pointwise_conv_engine #(.WIDTH(16), .FRAC(8), .CHIN(4), .COUT(2), .WOUT(2), .RELU(1)) dut0 (
        .clk(clk), .rst(rst_n), .start(start_s), .weight_addr(waddr_s0), .weight_data(wdata_s),
        .bias(bias_s), .layer_done(done_s0), .done_ack(ack_s), .stream(s0.slave));

    pointwise_conv_engine #(.WIDTH(16), .FRAC(8), .CHIN(4), .COUT(2), .WOUT(2), .RELU(0)) dut1 (
        .clk(clk), .rst(rst_n), .start(start_s), .weight_addr(waddr_s1), .weight_data(wdata_s),
        .bias(bias_s), .layer_done(done_s1), .done_ack(ack_s), .stream(s1.slave));

    typedef struct {
        int               cyc;
        int               pix;
        logic [1:0][15:0] o0;
        logic [1:0][15:0] o1;
    } rec_s_t;
    rec_s_t q_s[$];

    always @(negedge clk)
        if (s0.ofm_valid === 1'b1) q_s.push_back('{cyc, int'(s0.ofm_pix), s0.ofm, s1.ofm});

    // ---------------- default-size instance ----------------
    logic                  start_d = 1'b0, ack_d = 1'b0, done_d;
    logic [8:0]            waddr_d;
    logic [CO_D-1:0][15:0] wdata_d, bias_d;
    logic [CO_D-1:0][15:0] rom_d [CH_D];
    int                    ifm_d [NP_D*CH_D];

    pointwise_conv_engine_if #(.WIDTH(16), .COUT(CO_D), .WOUT(8)) sd ();
    assign wdata_d = rom_d[waddr_d];

    pointwise_conv_engine dutd (
        .clk(clk), .rst(rst_n), .start(start_d), .weight_addr(waddr_d), .weight_data(wdata_d),
        .bias(bias_d), .layer_done(done_d), .done_ack(ack_d), .stream(sd.slave));

    typedef struct {
        int                    cyc;
        int                    pix;
        logic [CO_D-1:0][15:0] o;
    } rec_d_t;
    rec_d_t q_d[$];

    always @(negedge clk)
        if (sd.ofm_valid === 1'b1) q_d.push_back('{cyc, int'(sd.ofm_pix), sd.ofm});

    // ---------------- reference model ----------------
    function automatic longint ref_out(longint acc, longint b, int frac, bit relu);
        longint d, num, q;
        d   = longint'(1) << frac;
        num = acc + b * d;
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    function automatic longint exp_s(int p, int j, bit relu);
        longint acc = 0;
        for (int c = 0; c < CH_S; c++)
            acc += longint'(ifm_s[p*CH_S+c]) * longint'($signed(rom_s[c][j]));
        return ref_out(acc, longint'($signed(bias_s[j])), 8, relu);
    endfunction

    function automatic longint exp_d(int p, int j);
        longint acc = 0;
        for (int c = 0; c < CH_D; c++)
            acc += longint'(ifm_d[p*CH_D+c]) * longint'($signed(rom_d[c][j]));
        return ref_out(acc, longint'($signed(bias_d[j])), 14, 1'b1);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic fill_const_s(int x, int w, int b);
        for (int i = 0; i < NP_S*CH_S; i++) ifm_s[i] = x;
        for (int c = 0; c < CH_S; c++) rom_s[c] = {16'(w), 16'(w)};
        bias_s = {16'(b), 16'(b)};
    endtask

    task automatic fill_rand_s();
        for (int i = 0; i < NP_S*CH_S; i++) ifm_s[i] = int'($urandom_range(1024)) - 512;
        for (int c = 0; c < CH_S; c++)
            for (int j = 0; j < 2; j++) rom_s[c][j] = 16'(int'($urandom_range(1024)) - 512);
        for (int j = 0; j < 2; j++) bias_s[j] = 16'(int'($urandom_range(8192)) - 4096);
    endtask

    task automatic run_layer_s(input int stall_pct, input int abort_idx, input bit poke_start, output int e0);
        int idx = 0;
        int guard = 0;
        bit v;
        e0 = -1;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        while (idx < NP_S*CH_S && guard < 1000) begin
            if (idx == abort_idx) begin
                rst_n = 1'b0;
                #1;
                check("rst_ifm_ready", s0.ifm_ready, 0);
                check("rst_weight_addr", waddr_s0, 0);
                check("rst_ofm", s0.ofm, 0);
                check("rst_ofm_valid", s0.ofm_valid, 0);
                check("rst_ofm_pix", s0.ofm_pix, 0);
                check("rst_layer_done", done_s0, 0);
                s0.ifm_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            s0.ifm       = 16'(ifm_s[idx]);
            v            = ($urandom_range(99) >= stall_pct);
            s0.ifm_valid = v;
            start_s      = poke_start && (guard == 3);
            if (v && s0.ifm_ready) begin
                if (idx == NP_S*CH_S - 1) e0 = cyc + 1;
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        s0.ifm_valid = 1'b0;
        start_s      = 1'b0;
        check("xfer_budget", idx, NP_S*CH_S);
    endtask

    task automatic wait_done_s(output int cd);
        int g = 0;
        while (done_s0 !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        cd = cyc;
        check("done_reached", done_s0, 1);
        check("done_pair", done_s1, done_s0);
    endtask

    task automatic ack_pulse_s();
        @(posedge clk); #1 ack_s = 1'b1;
        @(posedge clk); #1 ack_s = 1'b0;
        check("ack_done_low", done_s0, 0);
        check("ack_ready_low", s0.ifm_ready, 0);
    endtask

    task automatic check_layer_s(input string nm);
        check({nm, "_npulse"}, q_s.size(), NP_S);
        foreach (q_s[k]) begin
            check({nm, "_pix"}, q_s[k].pix, k);
            for (int j = 0; j < 2; j++) begin
                check({nm, "_relu1"}, $signed(q_s[k].o0[j]), exp_s(k, j, 1'b1));
                check({nm, "_relu0"}, $signed(q_s[k].o1[j]), exp_s(k, j, 1'b0));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     e0, cd, idx, guard, g;
        rec_s_t ref_q[$];
        s0.ifm = '0; s0.ifm_valid = 1'b0;
        sd.ifm = '0; sd.ifm_valid = 1'b0;
        bias_d = '0;
        fill_const_s(0, 0, 0);
        for (int c = 0; c < CH_D; c++) rom_d[c] = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_ifm_ready", s0.ifm_ready, 0);
        check("reset_weight_addr", waddr_s0, 0);
        check("reset_ofm", s0.ofm, 0);
        check("reset_ofm_valid", s0.ofm_valid, 0);
        check("reset_ofm_pix", s0.ofm_pix, 0);
        check("reset_layer_done", done_s0, 0);
        check("reset_d_ready", sd.ifm_ready, 0);
        check("reset_d_waddr", waddr_d, 0);
        rst_n = 1'b1;

        // ones: 1.0*1.0 over 4 channels + 0.5 bias = 4.5
        fill_const_s(256, 256, 128);
        run_layer_s(0, -1, 1'b0, e0);
        wait_done_s(cd);
        check_layer_s("ones");
        check("ones_value", $signed(q_s[0].o0[0]), 1152);
        check("ones_latency", q_s[NP_S-1].cyc, e0 + 2);
        check("ones_done_cycle", cd, q_s[NP_S-1].cyc + 1);
        for (int k = 1; k < NP_S; k++) check("ones_period", q_s[k].cyc - q_s[k-1].cyc, CH_S);
        ack_pulse_s();
        q_s.delete();

        // negative result: clamped with ReLU, signed without
        fill_const_s(256, -256, 0);
        run_layer_s(0, -1, 1'b0, e0);
        wait_done_s(cd);
        check_layer_s("neg");
        check("neg_relu_value", $signed(q_s[0].o0[0]), 0);
        check("neg_signed_value", $signed(q_s[0].o1[0]), -1024);
        ack_pulse_s();
        q_s.delete();

        // positive saturation
        fill_const_s(32767, 32767, 0);
        run_layer_s(0, -1, 1'b0, e0);
        wait_done_s(cd);
        check_layer_s("sat");
        check("sat_value", $signed(q_s[0].o1[1]), 32767);
        ack_pulse_s();
        q_s.delete();

        // random data without then with stalls; also a start pulse during RUN
        fill_rand_s();
        run_layer_s(0, -1, 1'b0, e0);
        wait_done_s(cd);
        check_layer_s("rand");
        ref_q = q_s;
        ack_pulse_s();
        q_s.delete();
        run_layer_s(50, -1, 1'b1, e0);
        wait_done_s(cd);
        check_layer_s("stall");
        foreach (q_s[k]) begin
            check("stall_vs_nostall0", q_s[k].o0, ref_q[k].o0);
            check("stall_vs_nostall1", q_s[k].o1, ref_q[k].o1);
        end
        q_s.delete();

        // DONE holds while done_ack is low; start in DONE is ignored
        for (int i = 0; i < 10; i++) begin
            start_s = (i == 3);
            @(posedge clk); #1;
            check("hold_done", done_s0, 1);
            check("hold_ready", s0.ifm_ready, 0);
        end
        start_s = 1'b0;
        ack_pulse_s();

        // restart after ack begins again at pixel 0
        fill_rand_s();
        run_layer_s(0, -1, 1'b0, e0);
        wait_done_s(cd);
        check_layer_s("restart");
        ack_pulse_s();
        q_s.delete();

        // reset at pixel 1 channel 2, then a clean layer with no residue
        fill_rand_s();
        run_layer_s(0, 1*CH_S + 2, 1'b0, e0);
        q_s.delete();
        fill_rand_s();
        ack_s = 1'b1;
        run_layer_s(0, -1, 1'b0, e0);
        wait_done_s(cd);
        @(negedge clk);
        check("ack_held_one_cycle", done_s0, 0);
        ack_s = 1'b0;
        check_layer_s("rst_rerun");
        q_s.delete();

        // full default-size layer
        for (int i = 0; i < NP_D*CH_D; i++) ifm_d[i] = int'($urandom_range(4096)) - 2048;
        for (int c = 0; c < CH_D; c++)
            for (int j = 0; j < CO_D; j++) rom_d[c][j] = 16'(int'($urandom_range(4096)) - 2048);
        for (int j = 0; j < CO_D; j++) bias_d[j] = 16'(int'($urandom_range(8192)) - 4096);
        @(posedge clk); #1 start_d = 1'b1;
        @(posedge clk); #1 start_d = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < NP_D*CH_D && guard < 40000) begin
            sd.ifm       = 16'(ifm_d[idx]);
            sd.ifm_valid = 1'b1;
            if (sd.ifm_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        sd.ifm_valid = 1'b0;
        check("d_xfer_budget", idx, NP_D*CH_D);
        g = 0;
        while (done_d !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("d_done", done_d, 1);
        check("d_npulse", q_d.size(), NP_D);
        foreach (q_d[k]) begin
            logic signed [63:0] gv;
            int bad;
            bad = 0;
            check("d_pix", q_d[k].pix, k);
            if (k > 0) check("d_period", q_d[k].cyc - q_d[k-1].cyc, CH_D);
            for (int j = 0; j < CO_D; j++) begin
                gv = $signed(q_d[k].o[j]);
                if (gv !== exp_d(k, j)) begin
                    bad = j;
                    break;
                end
            end
            check("d_ofm", $signed(q_d[k].o[bad]), exp_d(k, bad));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
